attack_turn_ctrl: RTL and testbench

Two-player turn scheduler for the shared attack datapath. It owns the right to strike and accepts fire requests only from the player whose turn it is. It validates the target cell, issues a one-cycle attack strobe to that player's attack-grid instance, then reports hit/miss and detects the win. Sits between the two players' cursor/fire logic and the two attack-grid registers (grid A = player 0's shots on player 1's board; grid B = the reverse).

---
 rtl/attack_turn_ctrl.sv | 153 +++++++++++++++
 tb/tb_attack_turn_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/attack_turn_ctrl.sv
// Two-player turn scheduler for the shared attack datapath: edge-detected fire, target
// validation, one-cycle strike strobe, hit/miss report and win detection. Optional macro: BONUS_SHOT_EN.
module attack_turn_ctrl #(
  parameter int unsigned CELLS       = 36,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fire_p0,
  input  logic             fire_p1,
  input  logic [CELLS-1:0] cursor_p0,
  input  logic [CELLS-1:0] cursor_p1,
  input  logic [CELLS-1:0] ships_p0,
  input  logic [CELLS-1:0] ships_p1,
  input  logic [CELLS-1:0] grid_a_state,
  input  logic [CELLS-1:0] grid_b_state,
  output logic             attack_a,
  output logic             attack_b,
  output logic [CELLS-1:0] attack_cursor,
  output logic             turn,
  output logic             hit,
  output logic             miss,
  output logic             reject,
  output logic             game_over,
  output logic             winner
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_WAIT, S_CHECK, S_STRIKE, S_RESULT, S_HOLD, S_DONE
  } state_t;

  state_t             state, state_n;
  logic               turn_n;
  logic [CELLS-1:0]   target, target_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               fire_q0, fire_q1;
  logic               edge0, edge1;
  logic [CELLS-1:0]   own_grid, opp_ships;
  logic               valid, shot_hit, win;
`ifdef BONUS_SHOT_EN
  logic               last_hit, last_hit_n;
`endif

  // Shared decode of the active player's view of the boards
  assign edge0     = fire_p0 & ~fire_q0;
  assign edge1     = fire_p1 & ~fire_q1;
  assign own_grid  = turn ? grid_b_state : grid_a_state;
  assign opp_ships = turn ? ships_p0 : ships_p1;
  assign valid     = $onehot(target) && ((target & own_grid) == '0);
  assign shot_hit  = |(target & opp_ships);
  assign win       = (opp_ships != '0) && ((opp_ships & ~own_grid) == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_WAIT;
      turn     <= 1'b0;
      target   <= '0;
      cnt      <= '0;
      fire_q0  <= 1'b0;
      fire_q1  <= 1'b0;
`ifdef BONUS_SHOT_EN
      last_hit <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      turn     <= turn_n;
      target   <= target_n;
      cnt      <= cnt_n;
      fire_q0  <= fire_p0;
      fire_q1  <= fire_p1;
`ifdef BONUS_SHOT_EN
      last_hit <= last_hit_n;
`endif
    end
  end

  always_comb begin
    state_n       = state;
    turn_n        = turn;
    target_n      = target;
    cnt_n         = cnt;
`ifdef BONUS_SHOT_EN
    last_hit_n    = last_hit;
`endif
    attack_a      = 1'b0;
    attack_b      = 1'b0;
    attack_cursor = target;
    hit           = 1'b0;
    miss          = 1'b0;
    reject        = 1'b0;
    game_over     = 1'b0;
    winner        = 1'b0;

    case (state)
      S_WAIT: begin
        // Only the active player's edge is served; the other is dropped
        if (!turn && edge0) begin
          target_n = cursor_p0;
          state_n  = S_CHECK;
        end else if (turn && edge1) begin
          target_n = cursor_p1;
          state_n  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (valid) begin
          state_n = S_STRIKE;
        end else begin
          reject  = 1'b1;
          state_n = S_WAIT;
        end
      end
      S_STRIKE: begin
        attack_a = ~turn;
        attack_b = turn;
        state_n  = S_RESULT;
      end
      S_RESULT: begin
        hit  = shot_hit;
        miss = ~shot_hit;
`ifdef BONUS_SHOT_EN
        last_hit_n = shot_hit;
`endif
        if (win) begin
          state_n = S_DONE;
        end else begin
          cnt_n   = CNT_W'(HOLD_CYCLES - 1);
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          state_n = S_WAIT;
`ifdef BONUS_SHOT_EN
          turn_n  = last_hit ? turn : ~turn;
`else
          turn_n  = ~turn;
`endif
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        game_over = 1'b1;
        winner    = turn;
      end
      default: state_n = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_attack_turn_ctrl.sv
// Directed bench for attack_turn_ctrl: per-cycle vector table plus hand sequences for
// rejects, win, held fire, empty ship map and reset during a strike. Honours BONUS_SHOT_EN.
module tb_attack_turn_ctrl;

  localparam int unsigned CELLS = 36;

`ifdef BONUS_SHOT_EN
  localparam logic BONUS = 1'b1;
`else
  localparam logic BONUS = 1'b0;
`endif

  localparam logic [CELLS-1:0] Z   = '0;
  localparam logic [CELLS-1:0] B0  = CELLS'(1) << 0;
  localparam logic [CELLS-1:0] B1  = CELLS'(1) << 1;
  localparam logic [CELLS-1:0] B2  = CELLS'(1) << 2;
  localparam logic [CELLS-1:0] B3  = CELLS'(1) << 3;
  localparam logic [CELLS-1:0] B4  = CELLS'(1) << 4;
  localparam logic [CELLS-1:0] B5  = CELLS'(1) << 5;
  localparam logic [CELLS-1:0] B7  = CELLS'(1) << 7;
  localparam logic [CELLS-1:0] B10 = CELLS'(1) << 10;
  localparam logic [CELLS-1:0] B20 = CELLS'(1) << 20;

  logic             clk = 1'b0;
  logic             reset;
  logic             fire_p0, fire_p1;
  logic [CELLS-1:0] cursor_p0, cursor_p1, ships_p0, ships_p1;
  logic [CELLS-1:0] grid_a_state, grid_b_state;
  logic             attack_a, attack_b, turn, hit, miss, reject, game_over, winner;
  logic [CELLS-1:0] attack_cursor;

  logic [CELLS-1:0] grid_a_pre, grid_b_pre, grid_a_hits, grid_b_hits;

  int tests = 0;
  int fails = 0;

  // ctl = {reset_before, fire_p0, fire_p1}; exp = {attack_a, attack_b, hit, miss, reject, game_over, turn}
  typedef struct {
    logic [2:0]       ctl;
    logic [CELLS-1:0] c0;
    logic [CELLS-1:0] c1;
    logic [6:0]       exp;
    logic [CELLS-1:0] cur;
  } vec_t;

  vec_t vecs[$];

  attack_turn_ctrl #(.CELLS(CELLS), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .fire_p0(fire_p0), .fire_p1(fire_p1),
    .cursor_p0(cursor_p0), .cursor_p1(cursor_p1),
    .ships_p0(ships_p0), .ships_p1(ships_p1),
    .grid_a_state(grid_a_state), .grid_b_state(grid_b_state),
    .attack_a(attack_a), .attack_b(attack_b), .attack_cursor(attack_cursor),
    .turn(turn), .hit(hit), .miss(miss), .reject(reject),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // Attack-grid model: records strikes, cleared by reset, plus a preset pattern
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      grid_a_hits <= '0;
      grid_b_hits <= '0;
    end else begin
      if (attack_a) grid_a_hits <= grid_a_hits | attack_cursor;
      if (attack_b) grid_b_hits <= grid_b_hits | attack_cursor;
    end
  end
  assign grid_a_state = grid_a_pre | grid_a_hits;
  assign grid_b_state = grid_b_pre | grid_b_hits;

  function automatic vec_t mk(input logic [2:0] ctl, input logic [CELLS-1:0] c0,
                              input logic [CELLS-1:0] c1, input logic [6:0] exp,
                              input logic [CELLS-1:0] cur);
    vec_t v;
    v.ctl = ctl; v.c0 = c0; v.c1 = c1; v.exp = exp; v.cur = cur;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 64'(act), 64'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("reset_outs", 64'({attack_a, attack_b, hit, miss, reject, game_over, winner, turn}), 64'd0);
    chk("reset_cursor", 64'(attack_cursor), 64'd0);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int strikes;
    reset = 1'b1;
    fire_p0 = 1'b0; fire_p1 = 1'b0;
    cursor_p0 = Z; cursor_p1 = Z;
    ships_p0 = B2 | B5; ships_p1 = B7 | B20;
    grid_a_pre = Z; grid_b_pre = Z;

    // Scenario A: player 0 hits bit 7
    vecs.push_back(mk(3'b110, B7, Z, 7'b0000000, B7));
    vecs.push_back(mk(3'b010, B7, Z, 7'b1000000, B7));
    vecs.push_back(mk(3'b000, B7, Z, 7'b0010000, B7));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(3'b000, B7, Z, 7'b0000000, B7));
    vecs.push_back(mk(3'b000, B7, Z, {6'b000000, ~BONUS}, B7));
    // Scenario B: inactive player ignored, simultaneous fire, p0 miss, p1 hit
    vecs.push_back(mk(3'b101, B10, B2, 7'b0000000, Z));
    vecs.push_back(mk(3'b000, B10, B2, 7'b0000000, Z));
    vecs.push_back(mk(3'b011, B10, B2, 7'b0000000, B10));
    vecs.push_back(mk(3'b011, B10, B2, 7'b1000000, B10));
    vecs.push_back(mk(3'b000, B10, B2, 7'b0001000, B10));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(3'b000, B10, B2, 7'b0000000, B10));
    vecs.push_back(mk(3'b000, B10, B2, 7'b0000001, B10));
    vecs.push_back(mk(3'b001, B10, B2, 7'b0000001, B2));
    vecs.push_back(mk(3'b000, B10, B2, 7'b0100001, B2));
    vecs.push_back(mk(3'b000, B10, B2, 7'b0010001, B2));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(3'b000, B10, B2, 7'b0000001, B2));
    vecs.push_back(mk(3'b000, B10, B2, {6'b000000, BONUS}, B2));

    foreach (vecs[i]) begin
      if (vecs[i].ctl[2]) do_reset();
      fire_p0   = vecs[i].ctl[1];
      fire_p1   = vecs[i].ctl[0];
      cursor_p0 = vecs[i].c0;
      cursor_p1 = vecs[i].c1;
      step();
      chk($sformatf("row%0d_outs", i),
          64'({attack_a, attack_b, hit, miss, reject, game_over, turn}), 64'(vecs[i].exp));
      chk($sformatf("row%0d_cursor", i), 64'(attack_cursor), 64'(vecs[i].cur));
    end

    // Reject: already-shot cell, then a non-one-hot cursor
    do_reset();
    grid_a_pre = B7; cursor_p0 = B7; fire_p0 = 1'b1;
    step();
    chk1("rej_dup", reject, 1'b1);
    fire_p0 = 1'b0;
    step();
    chk1("rej_dup_clear", reject, 1'b0);
    step();
    chk1("rej_dup_no_strike", attack_a, 1'b0);
    cursor_p0 = B3 | B4; fire_p0 = 1'b1;
    step();
    chk1("rej_multi", reject, 1'b1);
    fire_p0 = 1'b0;
    step();
    chk1("rej_multi_clear", reject, 1'b0);
    chk1("rej_multi_no_strike", attack_a, 1'b0);
    chk1("rej_turn", turn, 1'b0);
    grid_a_pre = Z;

    // Win: last remaining ship cell
    do_reset();
    grid_a_pre = B0; ships_p1 = B0 | B1; cursor_p0 = B1; fire_p0 = 1'b1;
    step();
    fire_p0 = 1'b0;
    step();
    chk1("win_strike", attack_a, 1'b1);
    step();
    chk1("win_hit", hit, 1'b1);
    chk1("win_not_yet_over", game_over, 1'b0);
    step();
    chk1("win_game_over", game_over, 1'b1);
    chk1("win_winner", winner, 1'b0);
    strikes = 0;
    for (int i = 0; i < 12; i++) begin
      fire_p0 = 1'(i % 2);
      fire_p1 = 1'((i / 2) % 2);
      step();
      strikes += int'(attack_a) + int'(attack_b);
    end
    chk("done_no_strikes", 64'(strikes), 64'd0);
    chk1("done_sticky", game_over, 1'b1);
    chk1("done_turn_frozen", turn, 1'b0);
    fire_p0 = 1'b0; fire_p1 = 1'b0;
    grid_a_pre = Z; ships_p1 = B7 | B20;

    // Held fire: one strike only; then edges during HOLD are dropped
    do_reset();
    cursor_p0 = B10; fire_p0 = 1'b1;
    strikes = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      strikes += int'(attack_a);
    end
    chk("held_one_strike", 64'(strikes), 64'd1);
    chk1("held_turn_after_miss", turn, 1'b1);
    fire_p0 = 1'b0;
    cursor_p1 = B5; fire_p1 = 1'b1;
    step();
    fire_p1 = 1'b0;
    strikes = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      strikes += int'(attack_b);
      if (i == 1) chk1("p1_hit", hit, 1'b1);
      if (i == 2 || i == 4) fire_p1 = 1'b1;
      if (i == 3) fire_p1 = 1'b0;
    end
    chk("hold_edges_dropped", 64'(strikes), 64'd1);
    chk1("hold_turn_after_p1_hit", turn, BONUS);
    fire_p1 = 1'b0;

    // Empty opponent ship map never wins
    do_reset();
    ships_p1 = Z; cursor_p0 = B10; fire_p0 = 1'b1;
    step();
    fire_p0 = 1'b0;
    step();
    step();
    chk1("empty_miss", miss, 1'b1);
    step();
    chk1("empty_no_win", game_over, 1'b0);
    repeat (4) step();
    chk1("empty_turn", turn, 1'b1);
    chk1("empty_still_no_win", game_over, 1'b0);
    ships_p1 = B7 | B20;

    // Reset during a player-1 strike
    cursor_p1 = B20; fire_p1 = 1'b1;
    step();
    fire_p1 = 1'b0;
    step();
    chk1("rst_mid_strike_seen", attack_b, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_outs", 64'({attack_a, attack_b, hit, miss, reject, game_over, winner, turn}), 64'd0);
    chk("rst_mid_cursor", 64'(attack_cursor), 64'd0);
    #1;
    reset = 1'b0;
    step();
    chk("rst_mid_idle", 64'({attack_a, attack_b, turn}), 64'd0);
    cursor_p0 = B10; fire_p0 = 1'b1;
    step();
    fire_p0 = 1'b0;
    step();
    chk1("rst_mid_p0_serves", attack_a, 1'b1);
    repeat (8) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
